// File: rtl/uart_transmisor_if.sv
// Handshake and serial-line bundle for uart_transmisor.
// The master side supplies bytes; the slave side is the transmitter.
interface uart_transmisor_if;
    logic [7:0] tx_byte;
    logic       send;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output tx_byte,
        output send,
        input  in_ready,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  tx_byte,
        input  send,
        output in_ready,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_transmisor.sv
// 8N1 UART transmitter with a one-byte holding slot for gapless back-to-back frames.
// tx is registered; busy/done/in_ready decode directly from state registers.
module uart_transmisor #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input logic              clk,
    input logic              reset,
    uart_transmisor_if.slave bus
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      slot_q, slot_d;
    logic            slot_full_q, slot_full_d;
    logic            tx_q, tx_d;

    logic bit_end;
    logic accept;
    logic stop_end;
    logic load_direct;
    logic in_ready;
    logic busy;
    logic done;

    assign bit_end  = (cnt_q == CntMax);
    assign accept   = bus.send && !slot_full_q;
    assign stop_end = (state_q == StStop) && bit_end;
    // Bytes bypass the slot when the shifter is free on this very edge.
    assign load_direct = accept && ((state_q == StIdle) || stop_end);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StStart;
            StStart: if (bit_end) state_d = StData;
            StData:  if (bit_end && (idx_q == 3'd7)) state_d = StStop;
            StStop:  if (bit_end) state_d = (slot_full_q || accept) ? StStart : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = ((state_q == StIdle) || bit_end) ? '0 : cnt_q + CntW'(1);

        idx_d = idx_q;
        if ((state_q == StData) && bit_end) begin
            idx_d = (idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;
        end

        shift_d = shift_q;
        if (load_direct) begin
            shift_d = bus.tx_byte;
        end else if (stop_end && slot_full_q) begin
            shift_d = slot_q;
        end

        slot_d      = slot_q;
        slot_full_d = slot_full_q;
        if (stop_end && slot_full_q) begin
            slot_full_d = 1'b0;
        end
        if (accept && !load_direct) begin
            slot_d      = bus.tx_byte;
            slot_full_d = 1'b1;
        end

        // Line level is derived from the next state so tx changes on the same edge.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            slot_q      <= 8'h00;
            slot_full_q <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            slot_q      <= slot_d;
            slot_full_q <= slot_full_d;
            tx_q        <= tx_d;
        end
    end

    always_comb begin
        in_ready = !slot_full_q;
        busy     = (state_q != StIdle);
        done     = stop_end;
    end

    assign bus.in_ready = in_ready;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.tx       = tx_q;

endmodule

// File: tb/tb_uart_transmisor.sv
// Directed bench for uart_transmisor at CLKS_PER_BIT=4: per-cycle schedules are applied
// on falling edges and the sampled waveforms are compared with hand-built frames.
module tb_uart_transmisor;

    logic clk = 1'b0;
    logic reset;

    uart_transmisor_if bus ();

    uart_transmisor #(
        .CLKS_PER_BIT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       s_send [256];
    logic [7:0] s_byte [256];
    logic       s_rst  [256];
    logic       c_tx   [256];
    logic       c_busy [256];
    logic       c_done [256];
    logic       c_rdy  [256];

    // Frame vectors: bit i is the i-th bit on the line (start, d0..d7, stop).
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 256; i++) begin
            s_send[i] = 1'b0;
            s_byte[i] = 8'h00;
            s_rst[i]  = 1'b1;
        end
    endtask

    // Sample outputs at each falling edge, then drive that cycle's inputs.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c_tx[i]     = bus.tx;
            c_busy[i]   = bus.busy;
            c_done[i]   = bus.done;
            c_rdy[i]    = bus.in_ready;
            bus.send    = s_send[i];
            bus.tx_byte = s_byte[i];
            reset       = s_rst[i];
        end
    endtask

    task automatic chk_frame(input string name, input int st, input logic [9:0] v);
        logic [39:0] g, e, b;
        for (int j = 0; j < 40; j++) begin
            g[j] = c_tx[st+j];
            e[j] = v[j/4];
            b[j] = c_busy[st+j];
        end
        chk({name, ".tx"}, 64'(g), 64'(e));
        chk({name, ".busy"}, 64'(b), 64'hFF_FFFF_FFFF);
    endtask

    task automatic chk_done_cnt(input string name, input int lo, input int hi, input int exp);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (c_done[i] === 1'b1) n++;
        chk(name, 64'(n), 64'(exp));
    endtask

    task automatic chk_idle(input string name, input int lo, input int hi);
        int bad = 0;
        for (int i = lo; i <= hi; i++) begin
            if (c_tx[i] !== 1'b1 || c_busy[i] !== 1'b0 || c_done[i] !== 1'b0) bad++;
        end
        chk(name, 64'(bad), 64'd0);
    endtask

    initial begin
        vecs[0] = '{data: 8'h55, frame: 10'h2AA};
        vecs[1] = '{data: 8'hA3, frame: 10'h346};
        vecs[2] = '{data: 8'h3C, frame: 10'h278};
        vecs[3] = '{data: 8'h81, frame: 10'h302};

        reset       = 1'b0;
        bus.send    = 1'b0;
        bus.tx_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset.tx", 64'(bus.tx), 64'd1);
        chk("reset.busy", 64'(bus.busy), 64'd0);
        chk("reset.done", 64'(bus.done), 64'd0);
        chk("reset.in_ready", 64'(bus.in_ready), 64'd1);

        // Single idle sends; tx_byte is scrambled right after acceptance.
        for (int k = 0; k < 4; k++) begin
            clr();
            s_send[0] = 1'b1;
            s_byte[0] = vecs[k].data;
            for (int i = 1; i < 42; i++) s_byte[i] = ~vecs[k].data;
            run(42);
            chk($sformatf("single%0d.rdy", k), 64'(c_rdy[0]), 64'd1);
            chk_frame($sformatf("single%0d", k), 1, vecs[k].frame);
            chk_done_cnt($sformatf("single%0d.done_cnt", k), 0, 41, 1);
            chk($sformatf("single%0d.done40", k), 64'(c_done[40]), 64'd1);
            chk($sformatf("single%0d.idle41", k), 64'({c_busy[41], c_tx[41]}), 64'b01);
        end

        // A3 then 0F into the slot, then 77 while the slot is full.
        clr();
        s_send[0] = 1'b1; s_byte[0] = 8'hA3;
        for (int i = 1; i < 5; i++) s_byte[i] = 8'h5C;
        s_send[5] = 1'b1; s_byte[5] = 8'h0F;
        for (int i = 6; i < 10; i++) s_byte[i] = 8'hE7;
        for (int i = 10; i < 15; i++) begin s_send[i] = 1'b1; s_byte[i] = 8'h77; end
        for (int i = 15; i < 125; i++) s_byte[i] = 8'h99;
        run(125);
        chk("b2b.rdy5", 64'(c_rdy[5]), 64'd1);
        chk("b2b.rdy6", 64'(c_rdy[6]), 64'd0);
        chk("b2b.rdy40", 64'(c_rdy[40]), 64'd0);
        chk("b2b.rdy41", 64'(c_rdy[41]), 64'd1);
        chk_frame("b2b.A3", 1, 10'h346);
        chk_frame("b2b.0F", 41, 10'h21E);
        chk_done_cnt("b2b.done_cnt", 0, 124, 2);
        chk("b2b.done_pos", 64'({c_done[40], c_done[80]}), 64'b11);
        chk_idle("b2b.no_third", 81, 124);

        // 00 then FF back to back.
        clr();
        s_send[0] = 1'b1; s_byte[0] = 8'h00;
        s_send[1] = 1'b1; s_byte[1] = 8'hFF;
        run(90);
        chk_frame("zf.00", 1, 10'h200);
        chk_frame("zf.FF", 41, 10'h3FE);
        chk_done_cnt("zf.done_cnt", 0, 89, 2);
        chk_idle("zf.tail", 81, 89);

        // Request lands on the same edge the stop bit completes with an empty slot.
        clr();
        s_send[0] = 1'b1; s_byte[0] = 8'h55;
        s_send[40] = 1'b1; s_byte[40] = 8'h3C;
        run(85);
        chk_frame("edge.55", 1, 10'h2AA);
        chk_frame("edge.3C", 41, 10'h278);
        chk("edge.rdy41", 64'(c_rdy[41]), 64'd1);
        chk_done_cnt("edge.done_cnt", 0, 84, 2);

        // Reset during data bit 3 of C6 while 81 waits in the slot.
        clr();
        s_send[0] = 1'b1; s_byte[0] = 8'hC6;
        s_send[2] = 1'b1; s_byte[2] = 8'h81;
        s_rst[18] = 1'b0;
        run(90);
        chk("rst.start", 64'(c_tx[1]), 64'd0);
        chk("rst.slot_full", 64'(c_rdy[3]), 64'd0);
        chk("rst.after", 64'({c_tx[19], c_busy[19], c_rdy[19]}), 64'b101);
        chk_idle("rst.quiet", 19, 89);

        // Accept on the first edge after reset release.
        clr();
        s_rst[0] = 1'b0;
        s_send[1] = 1'b1; s_byte[1] = 8'h81;
        run(45);
        chk_frame("rel.81", 2, 10'h302);
        chk("rel.done", 64'(c_done[41]), 64'd1);

        // send held high with tx_byte changing every cycle.
        clr();
        for (int i = 0; i < 46; i++) begin s_send[i] = 1'b1; s_byte[i] = 8'hE1; end
        s_byte[0] = 8'h12;
        s_byte[1] = 8'h34;
        s_byte[41] = 8'h5A;
        run(125);
        chk_frame("hold.12", 1, 10'h224);
        chk_frame("hold.34", 41, 10'h268);
        chk_frame("hold.5A", 81, 10'h2B4);
        chk_done_cnt("hold.done_cnt", 0, 124, 3);
        chk_idle("hold.tail", 121, 124);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_transmisor.md
UART_TRANSMISOR -- requirements
Module: uart_transmisor

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 5208, giving clock cycles per bit (50 MHz, 9600 baud).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port tx_byte, input, 8 bits: the byte to transmit, sampled only on an accepted request.
REQ-005 The block SHALL have port send, input, 1 bit: transmit request, sampled every cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: high when a request will be accepted this cycle.
REQ-007 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a frame is on the line.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-010 The frame SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), with no parity.
REQ-011 Every bit SHALL last exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles.
REQ-012 The FSM SHALL have states IDLE, START, DATA and STOP.
- IDLE->START on an accepted request.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after 8 bits.
- STOP->START (slot full) or IDLE (slot empty) after CLKS_PER_BIT cycles.
REQ-013 A request SHALL be accepted when send=1 and in_ready=1 at a rising edge; send with in_ready=0 SHALL be ignored with no state change.
REQ-014 There SHALL be a one-byte holding slot, and in_ready SHALL equal "slot empty".
REQ-015 A request accepted in IDLE SHALL load the shifter directly (slot stays empty), with tx=0 from the cycle after the accepting edge.
REQ-016 A request accepted while not IDLE SHALL store tx_byte in the slot, and in_ready SHALL drop the next cycle.
REQ-017 At STOP completion with the slot full, the slot SHALL move to the shifter, the slot SHALL clear and START SHALL begin on the next cycle, with no idle cycle between the stop bit and the next start bit.
REQ-018 When a request is accepted on the same edge that STOP completes with the slot empty, the byte SHALL go directly to the shifter and START SHALL follow immediately, as in REQ-017.
REQ-019 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE; busy SHALL stay 1 across back-to-back frames.
REQ-020 done SHALL pulse for exactly 1 cycle, on the final cycle of each stop bit, once per frame, including between back-to-back frames.
REQ-021 tx SHALL be driven from a register, with no combinational path from send or tx_byte to tx.
REQ-022 The bit counter SHALL be wide enough for CLKS_PER_BIT-1 with no wrap inside a bit, and the data index SHALL be 3 bits with no wrap beyond bit 7.
REQ-023 tx_byte changing after acceptance SHALL NOT affect the frame in progress or the byte in the slot.

Reset
REQ-024 While reset=0 at a rising edge, the block SHALL go to IDLE, set tx=1, busy=0, done=0 and in_ready=1, empty the slot, and zero all counters.
REQ-025 Reset asserted mid-frame SHALL abort the frame, with tx=1 from the next cycle and the slot content discarded.
REQ-026 After reset is released, the block SHALL accept a request on the first edge with reset=1.

Verification (CLKS_PER_BIT=4)
REQ-027 Idle send of 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles, starting the cycle after acceptance; done pulses 40 cycles after acceptance; busy high for 40 cycles.
REQ-028 Send 0xA3, then send 0x0F 5 cycles later -> 0x0F is accepted and in_ready goes 0; the 0x0F start bit begins on the cycle after the 0xA3 stop bit ends; in_ready returns to 1 at that transfer; busy stays 1 for 80 cycles; 2 done pulses.
REQ-029 With the slot full (0xA3 on the line, 0x0F held), a third send of 0x77 -> ignored; exactly 2 frames appear on the line.
REQ-030 Send 0x00, then 0xFF back-to-back -> all 8 data bits 0 then all 1; each stop bit high for exactly 4 cycles; no extra transitions.
REQ-031 reset=0 during data bit 3 of 0xC6 with the slot full -> next cycle tx=1, busy=0 and in_ready=1; no done pulse; no frame follows until a new send.
REQ-032 send held high continuously from idle with changing tx_byte -> one byte accepted per frame slot, and each byte transmitted equals tx_byte at its accepting edge.
